ctrl_fsm_mc: RTL and testbench
==============================

Name: ctrl_fsm_mc

Overview:
- Multi-cycle control unit for the 16-bit processor; next generation of the single-cycle combinational decoder.
- Registers the 5-bit opcode and sequences each instruction through FETCH, EXEC, MEM and WB.
- Gates the datapath control fields (RegWrite, PcSel, MemEnable, MemWr, …) to the correct phase.
- Adds a data-memory handshake with timeout, sticky HALT, and configurable illegal-opcode handling.

Parameters:
- ALUCW, 5, width of ALUcntrl; the opcode is zero-extended or truncated to this width.
- MEM_TIMEOUT, 15, max MEM-state cycles waiting for mem_done before error; 0 disables the timeout.
- ILLEGAL_HALT, 0, 1: siic/rti (00010/00011) enter HALTED; 0: treated as NOP.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- instr_valid  in  1  fetched instruction present on opcode
- opcode  in  5  instr[15:11]
- instr_ready  out  1  FSM in FETCH; opcode accepted when instr_valid & instr_ready
- Zflag  in  1  Rs==0, sampled in EXEC
- Sflag  in  1  Rs<0, sampled in EXEC
- mem_done  in  1  data memory completed the access
- RegWrite  out  1  register-file write strobe, WB only
- PcSel  out  1  branch/jump target selected, valid EXEC..WB
- PcUpdate  out  1  one-cycle PC load strobe, WB only
- Pc2Reg  out  1  write PC+2 to register file
- MemEnable  out  1  data memory access, MEM only
- MemWr  out  1  data memory write, MEM only
- Val2Reg  out  1  1: memory data to register file; 0: ALU output
- ALUSel  out  1  immediate as ALU operand B
- Iformat  out  1  Rd taken from the I-format field
- ImmSel  out  3  {sign, size[1:0]}; size 00=5b, 01=8b, 10=11b
- LinkReg  out  2  write register: 00 Rd, 01 Rs, 10 R7
- ALUcntrl  out  ALUCW  ALU operation
- Halt  out  1  HALTED state
- Err  out  1  sticky; illegal opcode or memory timeout

Behaviour:
- **Reset:** all outputs are 0 and state is FETCH after the first clk edge with rst=1.
  - rst mid-instruction aborts the instruction; no RegWrite or PcUpdate is issued.
  - rst has priority over every other input.
- **FETCH:** instr_ready=1. On instr_valid, latch opcode and its decoded static fields → EXEC.
  - Static fields (Pc2Reg, Val2Reg, ALUSel, Iformat, ImmSel, LinkReg, ALUcntrl) hold from EXEC until the next fetch.
  - Static fields are 0 in FETCH.
- **EXEC** (1 cycle): latch Zflag/Sflag and compute PcSel.
  - LD/ST/STU → MEM.
  - HALT, or illegal opcode with ILLEGAL_HALT=1 → HALTED.
  - Everything else → WB.
- **MEM:** MemEnable=1; MemWr=1 for ST/STU; a wait counter increments each cycle.
  - mem_done → WB.
  - Counter reaching MEM_TIMEOUT with no mem_done → Err=1, then HALTED.
  - mem_done on the same cycle as the timeout is a success.
- **WB** (1 cycle): PcUpdate=1; RegWrite=1 if the opcode writes a register → FETCH. Fetch-to-fetch latency is 3 cycles, or 3+N with N memory wait cycles.
- **HALTED:** Halt=1; instr_ready=0; all strobes 0. Exit only by rst.
- **Decode table** (ImmSel / LinkReg / RegWrite / other):
  - HALT 00000: halt. NOP 00001: no writes.
  - J 00100: 110 / –; RegWrite=0; PcSel=1.
  - JAL 00110: 110 / 10; RegWrite=1; Pc2Reg=1; PcSel=1.
  - JR 00101: 101 / –; RegWrite=0; PcSel=1; ALUcntrl=01000.
  - JALR 00111: 101 / 10; RegWrite=1; Pc2Reg=1; PcSel=1; ALUcntrl=01000.
  - 010??, 101??: ALUSel=1; Iformat=1; ALUcntrl=opcode; ImmSel=100 if opcode[1]=0, else 000; RegWrite=1.
  - Branches 011??: ImmSel=101; RegWrite=0. PcSel = Z, ~Z, S, ~S for opcode[1:0] = 00, 01, 10, 11.
  - ST 10000: ImmSel=100; ALUcntrl=01000; ALUSel=1; RegWrite=0.
  - LD 10001: same as ST, plus Val2Reg=1, RegWrite=1, LinkReg=00.
  - STU 10011: same as ST, plus RegWrite=1 and LinkReg=01 (Rs receives the address).
  - LBI 11000: ImmSel=101; LinkReg=01; RegWrite=1.
  - SLBI 10010: ImmSel=001; LinkReg=01; RegWrite=1.
  - R-format 11001, 1101?, 111??: ALUSel=0; Iformat=0; ALUcntrl=opcode; RegWrite=1.
- **Illegal opcodes** 00010/00011: Err=1 in EXEC.
  - ILLEGAL_HALT=0: continue to WB as a NOP.
- **PcSel** is 0 in WB for non-control instructions; PcUpdate always loads the PC, either PC+2 or the target.

Test Plan:
- ADD (11011), instr_valid=1 → instr_ready low 2 cycles; WB: RegWrite=1, ALUSel=0, ALUcntrl=11011; back in FETCH after 3 cycles.
- BNEZ (01101) with Zflag=0 in EXEC → PcSel=1, PcUpdate=1 in WB, RegWrite=0; repeat with Zflag=1 → PcSel=0.
- LD (10001), mem_done after 4 cycles → MemEnable=1 and MemWr=0 for 4 MEM cycles; WB: RegWrite=1, Val2Reg=1; total 7 cycles.
- ST (10000) with MEM_TIMEOUT=3, mem_done never asserted → Err=1, Halt=1; instr_ready stays 0 until rst.
- JAL (00110) → WB: Pc2Reg=1, LinkReg=10, RegWrite=1, PcSel=1, ImmSel=110.
- siic (00010), ILLEGAL_HALT=0 → Err=1, no writes, next fetch accepted. HALT (00000) → Halt=1; rst pulsed in EXEC of a second LD → no RegWrite, outputs 0.

Source files
------------

// File: rtl/ctrl_fsm_mc_if.sv
// Handshake and control bundle between the multi-cycle controller and the datapath/memory side.
// The controller uses the master modport; the datapath/memory side uses slave.
interface ctrl_fsm_mc_if #(parameter int ALUCW = 5);
  logic             instr_valid;
  logic [4:0]       opcode;
  logic             instr_ready;
  logic             Zflag;
  logic             Sflag;
  logic             mem_done;
  logic             RegWrite;
  logic             PcSel;
  logic             PcUpdate;
  logic             Pc2Reg;
  logic             MemEnable;
  logic             MemWr;
  logic             Val2Reg;
  logic             ALUSel;
  logic             Iformat;
  logic [2:0]       ImmSel;
  logic [1:0]       LinkReg;
  logic [ALUCW-1:0] ALUcntrl;
  logic             Halt;
  logic             Err;

  modport master (
    input  instr_valid, opcode, Zflag, Sflag, mem_done,
    output instr_ready, RegWrite, PcSel, PcUpdate, Pc2Reg, MemEnable, MemWr,
           Val2Reg, ALUSel, Iformat, ImmSel, LinkReg, ALUcntrl, Halt, Err
  );

  modport slave (
    output instr_valid, opcode, Zflag, Sflag, mem_done,
    input  instr_ready, RegWrite, PcSel, PcUpdate, Pc2Reg, MemEnable, MemWr,
           Val2Reg, ALUSel, Iformat, ImmSel, LinkReg, ALUcntrl, Halt, Err
  );
endinterface

// File: rtl/ctrl_fsm_mc.sv
// Multi-cycle control unit: FETCH -> EXEC -> (MEM) -> WB, with a memory-wait timeout,
// sticky halt and a sticky error flag. All outputs are registered.
module ctrl_fsm_mc #(
  parameter int ALUCW        = 5,
  parameter int MEM_TIMEOUT  = 15,
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input logic            clk,
  input logic            rst,
  ctrl_fsm_mc_if.master  bus
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] TLAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, HALTED} state_t;

  typedef struct packed {
    logic             pc2reg;
    logic             val2reg;
    logic             alusel;
    logic             iformat;
    logic [2:0]       immsel;
    logic [1:0]       linkreg;
    logic [ALUCW-1:0] alu;
    logic             wr;
    logic             mem;
    logic             st;
    logic             illegal;
    logic             hlt;
  } dec_t;

  state_t          state;
  logic [4:0]      op;
  logic            cur_wr, cur_mem, cur_st, cur_ill, cur_hlt;
  logic [CW-1:0]   wcnt;
  dec_t            dnext;

  function automatic dec_t decode(input logic [4:0] o);
    dec_t d;
    d = '0;
    casez (o)
      5'b00000: d.hlt = 1'b1;
      5'b0001?: d.illegal = 1'b1;
      5'b00100: d.immsel = 3'b110;
      5'b00110: begin
        d.immsel = 3'b110; d.linkreg = 2'b10; d.wr = 1'b1; d.pc2reg = 1'b1;
      end
      5'b00101: begin
        d.immsel = 3'b101; d.alu = ALUCW'(5'b01000);
      end
      5'b00111: begin
        d.immsel = 3'b101; d.linkreg = 2'b10; d.wr = 1'b1; d.pc2reg = 1'b1;
        d.alu = ALUCW'(5'b01000);
      end
      5'b010??, 5'b101??: begin
        d.alusel = 1'b1; d.iformat = 1'b1; d.alu = ALUCW'(o); d.wr = 1'b1;
        d.immsel = o[1] ? 3'b000 : 3'b100;
      end
      5'b011??: d.immsel = 3'b101;
      5'b10000, 5'b10001, 5'b10011: begin
        d.immsel = 3'b100; d.alu = ALUCW'(5'b01000); d.alusel = 1'b1; d.mem = 1'b1;
        d.st = (o != 5'b10001);
        d.wr = (o != 5'b10000);
        d.val2reg = (o == 5'b10001);
        d.linkreg = (o == 5'b10011) ? 2'b01 : 2'b00;
      end
      5'b11000: begin
        d.immsel = 3'b101; d.linkreg = 2'b01; d.wr = 1'b1;
      end
      5'b10010: begin
        d.immsel = 3'b001; d.linkreg = 2'b01; d.wr = 1'b1;
      end
      5'b11001, 5'b1101?, 5'b111??: begin
        d.alu = ALUCW'(o); d.wr = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

  // Jumps always redirect; conditional branches pick Z/~Z/S/~S from the low opcode bits.
  function automatic logic pcsel_of(input logic [4:0] o, input logic z, input logic s);
    logic r;
    r = 1'b0;
    casez (o)
      5'b001??: r = 1'b1;
      5'b011??: begin
        case (o[1:0])
          2'b00:   r = z;
          2'b01:   r = ~z;
          2'b10:   r = s;
          default: r = ~s;
        endcase
      end
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign dnext = decode(bus.opcode);

  // instr_ready is registered, so the controller spends one idle FETCH cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= FETCH;
      op              <= '0;
      cur_wr          <= 1'b0;
      cur_mem         <= 1'b0;
      cur_st          <= 1'b0;
      cur_ill         <= 1'b0;
      cur_hlt         <= 1'b0;
      wcnt            <= '0;
      bus.instr_ready <= 1'b0;
      bus.RegWrite    <= 1'b0;
      bus.PcSel       <= 1'b0;
      bus.PcUpdate    <= 1'b0;
      bus.Pc2Reg      <= 1'b0;
      bus.MemEnable   <= 1'b0;
      bus.MemWr       <= 1'b0;
      bus.Val2Reg     <= 1'b0;
      bus.ALUSel      <= 1'b0;
      bus.Iformat     <= 1'b0;
      bus.ImmSel      <= '0;
      bus.LinkReg     <= '0;
      bus.ALUcntrl    <= '0;
      bus.Halt        <= 1'b0;
      bus.Err         <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          bus.instr_ready <= 1'b1;
          if (bus.instr_ready && bus.instr_valid) begin
            state           <= EXEC;
            op              <= bus.opcode;
            bus.instr_ready <= 1'b0;
            cur_wr          <= dnext.wr;
            cur_mem         <= dnext.mem;
            cur_st          <= dnext.st;
            cur_ill         <= dnext.illegal;
            cur_hlt         <= dnext.hlt;
            bus.Pc2Reg      <= dnext.pc2reg;
            bus.Val2Reg     <= dnext.val2reg;
            bus.ALUSel      <= dnext.alusel;
            bus.Iformat     <= dnext.iformat;
            bus.ImmSel      <= dnext.immsel;
            bus.LinkReg     <= dnext.linkreg;
            bus.ALUcntrl    <= dnext.alu;
            if (dnext.illegal) bus.Err <= 1'b1;
          end
        end
        EXEC: begin
          if (cur_hlt || (cur_ill && ILLEGAL_HALT)) begin
            state    <= HALTED;
            bus.Halt <= 1'b1;
          end else if (cur_mem) begin
            state         <= MEM;
            bus.MemEnable <= 1'b1;
            bus.MemWr     <= cur_st;
            bus.PcSel     <= pcsel_of(op, bus.Zflag, bus.Sflag);
            wcnt          <= '0;
          end else begin
            state        <= WB;
            bus.PcUpdate <= 1'b1;
            bus.RegWrite <= cur_wr;
            bus.PcSel    <= pcsel_of(op, bus.Zflag, bus.Sflag);
          end
        end
        // A completion on the final allowed cycle still counts as success.
        MEM: begin
          if (bus.mem_done) begin
            state         <= WB;
            bus.MemEnable <= 1'b0;
            bus.MemWr     <= 1'b0;
            bus.PcUpdate  <= 1'b1;
            bus.RegWrite  <= cur_wr;
          end else if ((MEM_TIMEOUT != 0) && (wcnt == TLAST)) begin
            state         <= HALTED;
            bus.MemEnable <= 1'b0;
            bus.MemWr     <= 1'b0;
            bus.PcSel     <= 1'b0;
            bus.Err       <= 1'b1;
            bus.Halt      <= 1'b1;
          end else begin
            wcnt <= wcnt + CW'(1);
          end
        end
        WB: begin
          state           <= FETCH;
          bus.instr_ready <= 1'b1;
          bus.RegWrite    <= 1'b0;
          bus.PcUpdate    <= 1'b0;
          bus.PcSel       <= 1'b0;
          bus.Pc2Reg      <= 1'b0;
          bus.Val2Reg     <= 1'b0;
          bus.ALUSel      <= 1'b0;
          bus.Iformat     <= 1'b0;
          bus.ImmSel      <= '0;
          bus.LinkReg     <= '0;
          bus.ALUcntrl    <= '0;
        end
        HALTED: begin
          bus.Halt        <= 1'b1;
          bus.instr_ready <= 1'b0;
          bus.RegWrite    <= 1'b0;
          bus.PcUpdate    <= 1'b0;
          bus.PcSel       <= 1'b0;
          bus.MemEnable   <= 1'b0;
          bus.MemWr       <= 1'b0;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_fsm_mc.sv
// Randomized self-checking bench for ctrl_fsm_mc against an opcode-table reference model.
module tb_ctrl_fsm_mc;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nChecks = 0;
  int   nPass = 0;
  logic errExp = 1'b0;

  ctrl_fsm_mc_if #(.ALUCW(5)) bus ();

  ctrl_fsm_mc #(.ALUCW(5), .MEM_TIMEOUT(TMO), .ILLEGAL_HALT(1'b0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference decode: {Pc2Reg, Val2Reg, ALUSel, Iformat, ImmSel, LinkReg, ALUcntrl}
  function automatic logic [13:0] refStatic(input logic [4:0] op);
    int o;
    logic pc2, v2r, als, ifm;
    logic [2:0] imm;
    logic [1:0] lr;
    logic [4:0] alu;
    o = int'(op);
    {pc2, v2r, als, ifm, imm, lr, alu} = '0;
    if (o == 6 || o == 7) begin pc2 = 1; lr = 2'd2; end
    if (o == 4 || o == 6) imm = 3'd6;
    if (o == 5 || o == 7) begin imm = 3'd5; alu = 5'd8; end
    if ((o >= 8 && o <= 11) || (o >= 20 && o <= 23)) begin
      als = 1; ifm = 1; alu = op; imm = op[1] ? 3'd0 : 3'd4;
    end
    if (o >= 12 && o <= 15) imm = 3'd5;
    if (o == 16 || o == 17 || o == 19) begin imm = 3'd4; alu = 5'd8; als = 1; end
    if (o == 17) v2r = 1;
    if (o == 19) lr = 2'd1;
    if (o == 24) begin imm = 3'd5; lr = 2'd1; end
    if (o == 18) begin imm = 3'd1; lr = 2'd1; end
    if (o >= 25) alu = op;
    return {pc2, v2r, als, ifm, imm, lr, alu};
  endfunction

  function automatic logic refWrites(input logic [4:0] op);
    int o;
    o = int'(op);
    return (o == 6 || o == 7 || (o >= 8 && o <= 11) || o >= 17);
  endfunction

  function automatic logic refPcSel(input logic [4:0] op, input logic z, input logic s);
    int o;
    o = int'(op);
    if (o >= 4 && o <= 7) return 1'b1;
    if (o == 12) return z;
    if (o == 13) return ~z;
    if (o == 14) return s;
    if (o == 15) return ~s;
    return 1'b0;
  endfunction

  function automatic logic [13:0] obsStatic();
    return {bus.Pc2Reg, bus.Val2Reg, bus.ALUSel, bus.Iformat, bus.ImmSel, bus.LinkReg, bus.ALUcntrl};
  endfunction

  task automatic doReset;
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.mem_done = 1'b0;
    tick;
    checkOutput("rst_outputs", 32'({bus.instr_ready, bus.RegWrite, bus.PcSel, bus.PcUpdate,
                                    bus.MemEnable, bus.MemWr, obsStatic(), bus.Halt, bus.Err}), 32'd0);
    rst = 1'b0;
    errExp = 1'b0;
    tick;
    checkOutput("rst_ready", 32'(bus.instr_ready), 32'd1);
  endtask

  // One instruction from FETCH to the following FETCH (or to HALTED, followed by a reset).
  task automatic applyStimulus(input logic [4:0] op, input logic z, input logic s, input int d);
    logic [13:0] st;
    logic isMem, isSt, halted;
    int o;
    o = int'(op);
    st = refStatic(op);
    isMem = (o == 16 || o == 17 || o == 19);
    isSt = (o == 16 || o == 19);
    halted = 1'b0;
    checkOutput("fetch_ready", 32'(bus.instr_ready), 32'd1);
    bus.instr_valid = 1'b1;
    bus.opcode = op;
    bus.Zflag = z;
    bus.Sflag = s;
    bus.mem_done = 1'b0;
    tick;
    bus.instr_valid = 1'b0;
    bus.opcode = 5'($urandom);
    if (o == 2 || o == 3) errExp = 1'b1;
    checkOutput("exec_ready", 32'(bus.instr_ready), 32'd0);
    checkOutput("exec_static", 32'(obsStatic()), 32'(st));
    checkOutput("exec_strobes", 32'({bus.RegWrite, bus.PcUpdate, bus.MemEnable, bus.MemWr}), 32'd0);
    checkOutput("exec_err", 32'(bus.Err), 32'(errExp));
    if (o == 0) begin
      tick;
      halted = 1'b1;
    end else if (isMem) begin
      for (int k = 1; k <= TMO; k++) begin
        tick;
        checkOutput("mem_strobes", 32'({bus.MemEnable, bus.MemWr, bus.RegWrite, bus.PcUpdate}),
                    32'({1'b1, isSt, 1'b0, 1'b0}));
        bus.mem_done = (k == d);
        if (k == d) begin
          tick;
          bus.mem_done = 1'b0;
          break;
        end
        if (k == TMO) begin
          tick;
          errExp = 1'b1;
          halted = 1'b1;
        end
      end
    end else begin
      tick;
    end

    if (halted) begin
      checkOutput("halt_flag", 32'(bus.Halt), 32'd1);
      checkOutput("halt_err", 32'(bus.Err), 32'(errExp));
      checkOutput("halt_strobes", 32'({bus.instr_ready, bus.RegWrite, bus.PcUpdate, bus.MemEnable, bus.MemWr}), 32'd0);
      bus.instr_valid = 1'b1;
      tick;
      tick;
      checkOutput("halt_sticky", 32'({bus.Halt, bus.instr_ready}), 32'b10);
      doReset;
    end else begin
      checkOutput("wb_halt", 32'(bus.Halt), 32'd0);
      checkOutput("wb_strobes", 32'({bus.PcUpdate, bus.RegWrite, bus.MemEnable, bus.MemWr}),
                  32'({1'b1, refWrites(op), 1'b0, 1'b0}));
      checkOutput("wb_pcsel", 32'(bus.PcSel), 32'(refPcSel(op, z, s)));
      checkOutput("wb_static", 32'(obsStatic()), 32'(st));
      checkOutput("wb_err", 32'(bus.Err), 32'(errExp));
      tick;
      checkOutput("next_fetch", 32'({bus.instr_ready, bus.PcUpdate, bus.RegWrite, bus.PcSel, obsStatic()}),
                  32'({1'b1, 17'd0}));
    end
  endtask

  initial begin
    logic [4:0] rop;
    bus.instr_valid = 1'b0;
    bus.opcode = 5'd0;
    bus.Zflag = 1'b0;
    bus.Sflag = 1'b0;
    bus.mem_done = 1'b0;
    doReset;

    applyStimulus(5'b11011, 1'b0, 1'b0, 0);
    applyStimulus(5'b01101, 1'b0, 1'b0, 0);
    applyStimulus(5'b01101, 1'b1, 1'b0, 0);
    applyStimulus(5'b10001, 1'b0, 1'b0, TMO);
    applyStimulus(5'b10000, 1'b0, 1'b0, TMO + 1);
    applyStimulus(5'b00110, 1'b0, 1'b0, 0);
    applyStimulus(5'b00010, 1'b0, 1'b0, 0);
    applyStimulus(5'b00001, 1'b0, 1'b0, 0);
    applyStimulus(5'b00000, 1'b0, 1'b0, 0);

    // Reset while an LD is in EXEC must abort it without any write strobe.
    bus.instr_valid = 1'b1;
    bus.opcode = 5'b10001;
    tick;
    bus.instr_valid = 1'b0;
    rst = 1'b1;
    tick;
    checkOutput("abort_outputs", 32'({bus.instr_ready, bus.RegWrite, bus.PcUpdate, bus.MemEnable,
                                      obsStatic(), bus.Halt, bus.Err}), 32'd0);
    rst = 1'b0;
    errExp = 1'b0;
    tick;
    checkOutput("abort_ready", 32'(bus.instr_ready), 32'd1);

    for (int i = 0; i < 200; i++) begin
      rop = 5'($urandom_range(0, 31));
      applyStimulus(rop, 1'($urandom), 1'($urandom), $urandom_range(1, TMO + 2));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
